// File: rtl/sensor_sched_pkg.sv
// Shared constants and state encoding for the sensor scan scheduler.
package sensor_sched_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  // Supported co-processor latency range (cycles from data change to valid Q).
  localparam int CP_LATENCY_MIN = 2;
  localparam int CP_LATENCY_MAX = 15;

  // Scan FSM states, kept as plain constants for compatibility with older tools.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_ISSUE   = 2'd1;
  localparam state_t S_WAIT    = 2'd2;
  localparam state_t S_CAPTURE = 2'd3;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick: first pending channel at or above ptr, with wrap.
module rr_arbiter4
  import sensor_sched_pkg::*;
(
  input  logic [NCH-1:0]   pend,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest pending channel wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise synthesis infers latches.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int off = NCH - 1; off >= 0; off--) begin
      if (pend[ptr + SEL_W'(off)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ptr + SEL_W'(off);
      end
    end
  end

endmodule

// File: rtl/sensor_scan_scheduler.sv
// Shares one change-detect co-processor among four sensor requesters.
// Grants one sample at a time round-robin, waits out the co-processor
// latency, then records sticky flags, a saturating count and an interrupt.
module sensor_scan_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int DW         = 8,
  parameter int CP_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] sample_bus,
  input  logic [3:0]      ch_en,
  output logic [3:0]      ack,
  output logic [DW-1:0]   cp_data,
  output logic [1:0]      cp_sel,
  input  logic            cp_q,
  input  logic [1:0]      cp_q1,
  input  logic [3:0]      evt_clr,
  input  logic            cnt_clr,
  input  logic            irq_en,
  output logic [3:0]      evt_flags,
  output logic [7:0]      evt_count,
  output logic            err,
  output logic            irq,
  output logic            busy
);

  if (CP_LATENCY < CP_LATENCY_MIN || CP_LATENCY > CP_LATENCY_MAX) begin : g_bad_latency
    $error("sensor_scan_scheduler: CP_LATENCY out of supported range");
  end

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   cur_ch;
  logic [3:0]         wait_cnt;
  logic [NCH-1:0]     pend;
  logic               gnt_valid;
  logic [SEL_W-1:0]   gnt_idx;
  logic               hit;
  logic [NCH-1:0]     set_vec;
  logic [DW-1:0]      samples [NCH];

  assign pend    = req & ch_en;
  assign busy    = (state != S_IDLE);
  assign hit     = (state == S_CAPTURE) && cp_q;
  assign set_vec = hit ? (NCH'(1) << cur_ch) : '0;

  // Split the flat sample bus into one word per channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      samples[i] = sample_bus[DW*i +: DW];
    end
  end

  rr_arbiter4 u_arb (
    .pend      (pend),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Scan FSM: grant, issue to the co-processor, wait out its latency, capture.
  // cp_data/cp_sel only move on a grant so idle recompares see stable data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cur_ch   <= '0;
      wait_cnt <= '0;
      ack      <= '0;
      cp_data  <= '0;
      cp_sel   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            cur_ch  <= gnt_idx;
            cp_data <= samples[gnt_idx];
            cp_sel  <= gnt_idx;
            ack     <= NCH'(1) << gnt_idx;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= 4'(CP_LATENCY - 2);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_CAPTURE;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_CAPTURE: begin
          ptr   <= cur_ch + SEL_W'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Event bookkeeping: a capture set beats a same-cycle clear on both flags and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_flags <= '0;
      evt_count <= '0;
      err       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      evt_flags <= (evt_flags & ~evt_clr) | set_vec;
      if (cnt_clr)                        evt_count <= hit ? 8'd1 : 8'd0;
      else if (hit && evt_count != 8'hFF) evt_count <= evt_count + 8'd1;
      if (hit && cp_q1 != cur_ch)         err <= 1'b1;
      irq <= irq_en & (|evt_flags);
    end
  end

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Bench for sensor_scan_scheduler: a behavioural change-detect co-processor
// with override hooks, directed scenarios and a randomized run checked
// against a transaction-level model of the scheduler.
module tb_sensor_scan_scheduler;

  localparam int DW  = 8;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req, ch_en, evt_clr, ack, evt_flags;
  logic [4*DW-1:0] sample_bus;
  logic            cnt_clr, irq_en, cp_q, err, irq, busy;
  logic [1:0]      cp_sel, cp_q1;
  logic [DW-1:0]   cp_data;
  logic [7:0]      evt_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sensor_scan_scheduler #(.DW(DW), .CP_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .sample_bus (sample_bus),
    .ch_en      (ch_en),
    .ack        (ack),
    .cp_data    (cp_data),
    .cp_sel     (cp_sel),
    .cp_q       (cp_q),
    .cp_q1      (cp_q1),
    .evt_clr    (evt_clr),
    .cnt_clr    (cnt_clr),
    .irq_en     (irq_en),
    .evt_flags  (evt_flags),
    .evt_count  (evt_count),
    .err        (err),
    .irq        (irq),
    .busy       (busy)
  );

  function automatic int absdiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Co-processor stand-in: registers data at E1, reports change at E2.
  // A change is a difference of 2 or more from the channel baseline.
  logic [DW-1:0] cpx_d;
  logic [1:0]    cpx_s, cpx_q1;
  logic          cpx_q;
  logic [DW-1:0] cpx_base [4];
  logic          force_q, force_q1_en;
  logic [1:0]    force_q1_val;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cpx_d  <= '0;
      cpx_s  <= '0;
      cpx_q  <= 1'b0;
      cpx_q1 <= '0;
      for (int i = 0; i < 4; i++) cpx_base[i] <= '0;
    end else begin
      cpx_d  <= cp_data;
      cpx_s  <= cp_sel;
      cpx_q1 <= cpx_s;
      cpx_q  <= (absdiff(int'(cpx_d), int'(cpx_base[cpx_s])) >= 2);
      if (absdiff(int'(cpx_d), int'(cpx_base[cpx_s])) >= 2) cpx_base[cpx_s] <= cpx_d;
    end
  end

  assign cp_q  = force_q | cpx_q;
  assign cp_q1 = force_q1_en ? force_q1_val : cpx_q1;

  // Transaction-level reference model.
  int         cyc, m_ptr, m_free, m_cap_at, m_busy_until, m_cap_ch, m_cap_s, m_count;
  int         m_base [4];
  logic [3:0] m_flags, m_ack;
  logic       m_irq, m_err, m_busy;
  logic [7:0] m_data;
  logic [1:0] m_sel;

  function automatic int rr_pick(logic [3:0] p, int ptr);
    for (int o = 0; o < 4; o++) if (p[(ptr + o) % 4]) return (ptr + o) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    cyc = 0; m_ptr = 0; m_free = 0; m_cap_at = -1; m_busy_until = 0;
    m_cap_ch = 0; m_cap_s = 0; m_count = 0;
    for (int i = 0; i < 4; i++) m_base[i] = 0;
    m_flags = '0; m_ack = '0; m_irq = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    m_data = '0; m_sel = '0;
  endtask

  task automatic set_sample(int ch, logic [7:0] v);
    sample_bus[ch*DW +: DW] = v;
  endtask

  // One clock: update the model from inputs seen at the edge, return at the
  // following falling edge, and have the requester drop any acked request.
  task automatic tick();
    logic [3:0] pend, set;
    bit         ev, inc;
    int         g, q1;
    @(posedge clk);
    pend  = req & ch_en;
    set   = '0;
    inc   = 1'b0;
    m_irq = irq_en & (m_flags != 4'b0);
    if (cyc == m_cap_at) begin
      ev = force_q;
      if (absdiff(m_cap_s, m_base[m_cap_ch]) >= 2) begin
        ev = 1'b1;
        m_base[m_cap_ch] = m_cap_s;
      end
      if (ev) begin
        set[m_cap_ch] = 1'b1;
        inc = 1'b1;
        q1 = force_q1_en ? int'(force_q1_val) : m_cap_ch;
        if (q1 != m_cap_ch) m_err = 1'b1;
      end
    end
    m_ack = '0;
    if (cyc >= m_free && pend != 4'b0) begin
      g = rr_pick(pend, m_ptr);
      m_ack[g]     = 1'b1;
      m_ptr        = (g + 1) % 4;
      m_free       = cyc + LAT + 2;
      m_cap_at     = cyc + LAT + 1;
      m_busy_until = cyc + LAT + 1;
      m_cap_ch     = g;
      m_cap_s      = int'(sample_bus[g*DW +: DW]);
      m_data       = sample_bus[g*DW +: DW];
      m_sel        = 2'(g);
    end
    m_busy  = (cyc < m_busy_until);
    m_flags = (m_flags & ~evt_clr) | set;
    if (cnt_clr)                   m_count = inc ? 1 : 0;
    else if (inc && m_count < 255) m_count++;
    @(negedge clk);
    cyc++;
    req = req & ~m_ack;
  endtask

  task automatic drain();
    req = '0;
    for (int i = 0; i < 20 && m_busy; i++) tick();
    tick();
  endtask

  logic [3:0] seq_ack [4];
  int         seq_cyc [4];
  int         seq_n;

  task automatic collect(logic [3:0] r);
    seq_n = 0;
    req = r;
    for (int i = 0; i < 24 && seq_n < 4; i++) begin
      tick();
      if (ack !== 4'b0) begin
        seq_ack[seq_n] = ack;
        seq_cyc[seq_n] = cyc;
        seq_n++;
      end
    end
    req = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; ch_en = '0; evt_clr = '0; cnt_clr = 1'b0; irq_en = 1'b0;
    sample_bus = '0; force_q = 1'b0; force_q1_en = 1'b0; force_q1_val = '0;
    @(negedge clk); @(negedge clk);
    checks++; if ({ack, cp_data, cp_sel, busy} !== '0)
      begin errors++; $display("FAIL reset_ctl got ack=%b data=%h sel=%0d busy=%b exp all 0", ack, cp_data, cp_sel, busy); end
    checks++; if ({evt_flags, evt_count, err, irq} !== '0)
      begin errors++; $display("FAIL reset_status got flags=%b cnt=%0d err=%b irq=%b exp all 0", evt_flags, evt_count, err, irq); end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_single();
    ch_en = 4'hF; irq_en = 1'b1;
    set_sample(2, 8'h50);
    req = 4'b0100;
    tick();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b exp=0100", ack); end
    checks++; if (cp_sel !== 2'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", cp_sel); end
    checks++; if (cp_data !== 8'h50) begin errors++; $display("FAIL single_data got=%h exp=50", cp_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
    tick(); tick();
    checks++; if (evt_flags !== 4'b0100) begin errors++; $display("FAIL single_flags got=%b exp=0100", evt_flags); end
    checks++; if (evt_count !== 8'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", evt_count); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_early got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got=%b exp=1", irq); end
  endtask

  task automatic test_small_diff();
    set_sample(2, 8'h51);
    req = 4'b0100;
    tick();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL small_ack got=%b exp=0100", ack); end
    tick(); tick(); tick();
    checks++; if (evt_flags !== 4'b0100) begin errors++; $display("FAIL small_flags got=%b exp=0100", evt_flags); end
    checks++; if (evt_count !== 8'd1) begin errors++; $display("FAIL small_count got=%0d exp=1", evt_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL small_err got=%b exp=0", err); end
  endtask

  task automatic test_round_robin();
    int exp_a [4];
    int exp_b [4];
    exp_a = '{0, 1, 2, 3};
    exp_b = '{2, 3, 0, 1};
    // A ch3 grant leaves the pointer at 0.
    set_sample(3, 8'h10);
    req = 4'b1000;
    drain_after_grant();
    set_sample(0, 8'h20); set_sample(1, 8'h30); set_sample(2, 8'hA0); set_sample(3, 8'h40);
    collect(4'hF);
    checks++; if (seq_n !== 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", seq_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seq_ack[i] !== (4'b0001 << exp_a[i]))
        begin errors++; $display("FAIL rr_order_a[%0d] got=%b exp=%b", i, seq_ack[i], 4'b0001 << exp_a[i]); end
      if (i > 0) begin
        checks++; if (seq_cyc[i] - seq_cyc[i-1] !== 4)
          begin errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=4", i, seq_cyc[i] - seq_cyc[i-1]); end
      end
    end
    drain();
    // Pointer back at 0: with ch0 and ch3 pending, ch0 must win.
    req = 4'b1001;
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rr_ptr0 got=%b exp=0001", ack); end
    drain();
    req = 4'b0010;
    drain_after_grant();
    collect(4'hF);
    checks++; if (seq_n !== 4) begin errors++; $display("FAIL rr_count_b got=%0d exp=4", seq_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seq_ack[i] !== (4'b0001 << exp_b[i]))
        begin errors++; $display("FAIL rr_order_b[%0d] got=%b exp=%b", i, seq_ack[i], 4'b0001 << exp_b[i]); end
    end
    drain();
  endtask

  task automatic drain_after_grant();
    tick();
    drain();
  endtask

  task automatic test_clear_collision();
    evt_clr = 4'hF;
    tick();
    evt_clr = '0;
    checks++; if (evt_flags !== 4'b0) begin errors++; $display("FAIL clr_all got=%b exp=0000", evt_flags); end
    set_sample(2, 8'h10);
    req = 4'b0100;
    tick();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL clr_ack got=%b exp=0100", ack); end
    tick(); tick();
    evt_clr = 4'b0100;
    tick();
    evt_clr = '0;
    checks++; if (evt_flags !== 4'b0100) begin errors++; $display("FAIL clr_set_wins got=%b exp=0100", evt_flags); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clr_irq_on got=%b exp=1", irq); end
    evt_clr = 4'b0100;
    tick();
    evt_clr = '0;
    checks++; if (evt_flags !== 4'b0) begin errors++; $display("FAIL clr_alone got=%b exp=0000", evt_flags); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq_off got=%b exp=0", irq); end
  endtask

  task automatic test_disabled_and_reset();
    ch_en = 4'b1011;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ack !== 4'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL dis_nogrant got ack=%b busy=%b exp ack=0000 busy=0", ack, busy); end
    end
    req = '0; ch_en = 4'hF;
    set_sample(0, 8'h77);
    req = 4'b0001;
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rst_ack got=%b exp=0001", ack); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_wait got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    checks++; if ({ack, cp_data, cp_sel, busy, evt_flags, evt_count, err, irq} !== '0)
      begin errors++; $display("FAIL rst_async got ack=%b data=%h sel=%0d busy=%b flags=%b cnt=%0d err=%b irq=%b exp all 0",
                                ack, cp_data, cp_sel, busy, evt_flags, evt_count, err, irq); end
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if ({evt_flags, evt_count, busy, ack} !== '0)
      begin errors++; $display("FAIL rst_nocapture got flags=%b cnt=%0d busy=%b ack=%b exp all 0", evt_flags, evt_count, busy, ack); end
  endtask

  task automatic test_err_and_saturation();
    int n_acks;
    force_q = 1'b1; force_q1_en = 1'b1; force_q1_val = 2'd3;
    req = 4'b0010;
    tick();
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL err_ack got=%b exp=0010", ack); end
    tick(); tick(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err); end
    force_q1_en = 1'b0;
    n_acks = 0;
    for (int i = 0; i < 2000 && n_acks < 300; i++) begin
      req = 4'hF & ~m_ack;
      tick();
      if (m_ack != 4'b0) n_acks++;
    end
    checks++; if (n_acks < 300) begin errors++; $display("FAIL sat_timeout got=%0d exp=300 grants", n_acks); end
    drain();
    checks++; if (evt_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", evt_count); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (evt_count !== 8'd0) begin errors++; $display("FAIL cnt_clr got=%0d exp=0", evt_count); end
    req = 4'b0001;
    tick(); tick(); tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (evt_count !== 8'd1) begin errors++; $display("FAIL cnt_clr_inc got=%0d exp=1", evt_count); end
    force_q = 1'b0;
    drain();
  endtask

  function automatic logic [7:0] pick_sample(int ch);
    if ($urandom_range(1) == 0) return 8'($urandom);
    return 8'(m_base[ch] + int'($urandom_range(2)));
  endfunction

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0)  ch_en  = 4'($urandom);
      if ($urandom_range(15) == 0) irq_en = 1'($urandom);
      evt_clr = ($urandom_range(9) == 0) ? 4'($urandom) : 4'b0;
      cnt_clr = ($urandom_range(40) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && !m_ack[i] && $urandom_range(3) == 0) begin
          set_sample(i, pick_sample(i));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(30) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
      checks++; if (ack !== m_ack) begin errors++; bad++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, ack, m_ack); end
      checks++; if (evt_flags !== m_flags) begin errors++; bad++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", cyc, evt_flags, m_flags); end
      checks++; if (evt_count !== 8'(m_count)) begin errors++; bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, evt_count, m_count); end
      checks++; if (irq !== m_irq || err !== m_err || busy !== m_busy)
        begin errors++; bad++; $display("FAIL rand_status cyc=%0d got irq=%b err=%b busy=%b exp irq=%b err=%b busy=%b", cyc, irq, err, busy, m_irq, m_err, m_busy); end
      checks++; if (cp_data !== m_data || cp_sel !== m_sel)
        begin errors++; bad++; $display("FAIL rand_cp cyc=%0d got data=%h sel=%0d exp data=%h sel=%0d", cyc, cp_data, cp_sel, m_data, m_sel); end
      if (bad > 20) break;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_small_diff();
    test_round_robin();
    test_clear_collision();
    test_disabled_and_reset();
    test_err_and_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
